// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types and constants used across the core.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC  = '0;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus4;
    logic            valid_if_id;
  } if_id_reg_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the fetch PC, keeps one imem request in flight,
// buffers a response across decode stalls and kills fetches on redirect.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC_P = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output if_id_reg_t      out
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            kill_q;
  if_id_reg_t      hold_q;

  if_id_reg_t      cur;
  logic [XLEN-1:0] nxt_pc;
  logic            rsp_ok;
  logic            consume;

  always_comb begin
    nxt_pc  = ((state == S_HOLD) ? hold_q.pc : req_pc_q) + XLEN'(4);
    rsp_ok  = (state == S_WAIT) && imem_rvalid && !kill_q;

    cur.pc          = pc_q;
    cur.instruction = NOP_INSTR;
    cur.pc_plus4    = pc_q + XLEN'(4);
    cur.valid_if_id = 1'b0;
    if (state == S_HOLD) begin
      cur = hold_q;
    end else if (rsp_ok) begin
      cur.pc          = req_pc_q;
      cur.instruction = imem_rdata;
      cur.pc_plus4    = nxt_pc;
      cur.valid_if_id = 1'b1;
    end
    if (redirect_valid) cur.valid_if_id = 1'b0;

    // A consumed instruction frees the slot, so the next request issues the
    // same cycle; this is what sustains one instruction per cycle.
    consume   = cur.valid_if_id && !stall;
    imem_req  = !reset && !redirect_valid && ((state == S_REQ) || consume);
    imem_addr = consume ? nxt_pc : pc_q;
  end

  assign out = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_REQ;
      pc_q               <= RESET_PC_P;
      req_pc_q           <= RESET_PC_P;
      kill_q             <= 1'b0;
      hold_q.pc          <= RESET_PC_P;
      hold_q.instruction <= NOP_INSTR;
      hold_q.pc_plus4    <= RESET_PC_P + XLEN'(4);
      hold_q.valid_if_id <= 1'b0;
    end else if (redirect_valid) begin
      pc_q               <= {redirect_pc[XLEN-1:2], 2'b00};
      hold_q.valid_if_id <= 1'b0;
      // An in-flight request whose response has not yet arrived must be
      // drained and discarded before a new request may be issued.
      if ((state == S_WAIT) && !imem_rvalid) begin
        kill_q <= 1'b1;
        state  <= S_WAIT;
      end else begin
        kill_q <= 1'b0;
        state  <= S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            req_pc_q <= pc_q;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_q <= 1'b0;
              state  <= S_REQ;
            end else if (!stall) begin
              pc_q <= nxt_pc;
              if (imem_ready) req_pc_q <= nxt_pc;
              else            state    <= S_REQ;
            end else begin
              hold_q <= cur;
              state  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_q               <= nxt_pc;
            hold_q.valid_if_id <= 1'b0;
            if (imem_ready) begin
              req_pc_q <= nxt_pc;
              state    <= S_WAIT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a latency-programmable imem model
// and a scoreboard of expected IF/ID payloads.
module tb_if_fetch_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  if_id_reg_t  out;

  if_fetch_stage #(.XLEN(32), .RESET_PC_P(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  if_id_reg_t  q[$];
  bit          pend;
  int          cnt;
  int          lat = 1;
  logic [31:0] paddr;

  logic        s_req;
  logic [31:0] s_addr;
  if_id_reg_t  s_out;
  bit          acc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cyc(input bit st, input bit rd, input logic [31:0] rpc, input bit rdy);
    if_id_reg_t e;
    imem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 0;
      end
    end
    stall = st; redirect_valid = rd; redirect_pc = rpc; imem_ready = rdy;
    #3;
    s_req = imem_req; s_addr = imem_addr; s_out = out;
    acc   = imem_req && imem_ready;
    if (imem_req) chk("one_outstanding", 128'(pend), 128'(0));
    if (rd) begin
      chk("redir_req_low", 128'(imem_req), 128'(0));
      chk("redir_valid_low", 128'(out.valid_if_id), 128'(0));
      q.delete();
    end else if (out.valid_if_id) begin
      if (q.size() == 0) chk("spurious_valid", 128'(out.valid_if_id), 128'(0));
      else begin
        chk("sb_out", 128'(out), 128'(q[0]));
        if (!st) void'(q.pop_front());
      end
    end
    if (acc) begin
      e.pc = imem_addr; e.instruction = mem_word(imem_addr);
      e.pc_plus4 = imem_addr + 32'd4; e.valid_if_id = 1'b1;
      q.push_back(e);
      pend = 1; cnt = lat; paddr = imem_addr;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    if_id_reg_t r;
    r.pc = 32'h0; r.instruction = 32'h0000_0013; r.pc_plus4 = 32'h4; r.valid_if_id = 1'b0;
    chk({tag, "_req"}, 128'(imem_req), 128'(0));
    chk({tag, "_out"}, 128'(out), 128'(r));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk_reset_outputs(tag);
    q.delete(); pend = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 0; cnt = 0; paddr = '0; acc = 0;
    #1 chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // back-to-back streaming with 1-cycle memory
    cyc(0, 0, 0, 1); chk("addr0", {s_req, s_addr}, {1'b1, 32'h0});
    cyc(0, 0, 0, 1); chk("addr4", {s_req, s_addr}, {1'b1, 32'h4});
    chk("pc0_valid", 128'(s_out.valid_if_id), 128'(1));
    cyc(0, 0, 0, 1); chk("addr8", {s_req, s_addr}, {1'b1, 32'h8});

    // stall 3 cycles while 0x8 returns
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1);
      chk("stall_no_req", 128'(s_req), 128'(0));
      chk("stall_pc", 128'(s_out.pc), 128'(32'h8));
    end
    cyc(0, 0, 0, 1); chk("after_stall_addr", {s_req, s_addr}, {1'b1, 32'hC});

    // redirect while 0x10 is outstanding, response two cycles later
    lat = 3;
    cyc(0, 0, 0, 1); chk("addr10", {s_req, s_addr}, {1'b1, 32'h10});
    lat = 1;
    cyc(0, 1, 32'h100, 1);
    cyc(0, 0, 0, 1); chk("kill_wait_req", 128'(s_req), 128'(0));
    cyc(0, 0, 0, 1); chk("kill_drop_valid", 128'(s_out.valid_if_id), 128'(0));
    chk("kill_drop_req", 128'(s_req), 128'(0));
    cyc(0, 0, 0, 1); chk("redir_addr100", {s_req, s_addr}, {1'b1, 32'h100});

    // redirect coincident with rvalid and stall
    cyc(1, 1, 32'h100, 1);
    cyc(0, 0, 0, 1); chk("coinc_addr100", {s_req, s_addr}, {1'b1, 32'h100});
    chk("coinc_hold_empty", 128'(s_out.valid_if_id), 128'(0));

    // imem_ready low: request held stable
    cyc(0, 0, 0, 0); chk("rdy_low_first", {s_req, s_addr}, {1'b1, 32'h104});
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk("rdy_low_req", {s_req, s_addr}, {1'b1, 32'h104});
      chk("rdy_low_valid", 128'(s_out.valid_if_id), 128'(0));
    end
    lat = 3;
    cyc(0, 0, 0, 1); chk("rdy_high_accept", {acc, s_addr}, {1'b1, 32'h104});

    // async reset while waiting
    do_reset("rst_wait");
    lat = 1;
    cyc(0, 0, 0, 1); chk("post_rst_addr", {s_req, s_addr}, {1'b1, 32'h0});
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1); chk("hold_before_rst", 128'(s_out.valid_if_id), 128'(1));

    // async reset while holding
    do_reset("rst_hold");
    cyc(0, 1, 32'h103, 1);
    cyc(0, 0, 0, 1); chk("align_addr100", {s_req, s_addr}, {1'b1, 32'h100});
    cyc(0, 0, 0, 1); chk("addr104", {s_req, s_addr}, {1'b1, 32'h104});

    // wrap of the PC adder
    cyc(0, 1, 32'hFFFF_FFFF, 1);
    cyc(0, 0, 0, 1); chk("addr_top", {s_req, s_addr}, {1'b1, 32'hFFFF_FFFC});
    cyc(0, 0, 0, 1); chk("wrap_addr", {s_req, s_addr}, {1'b1, 32'h0});
    chk("wrap_pc_plus4", 128'(s_out.pc_plus4), 128'(32'h0));
    cyc(0, 0, 0, 1); chk("post_wrap_addr", {s_req, s_addr}, {1'b1, 32'h4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
